// File: rtl/serial_signed_18x18_mul_responder.sv
// Serial signed 18x18 -> 36 multiplier, responder side of the a/b/input_rdy -> p/busy
// handshake used by the audio blocks. Sign-magnitude shift-add datapath: the operand
// magnitudes are multiplied unsigned, LSB of the multiplier first, and the sign is
// applied in a final FIX step.
//
// Build option: define SERIAL_MUL_RADIX4_EN to retire two multiplier bits per clock
// (9 iterations instead of 18). The port list and the handshake are the same in both builds.
module serial_signed_18x18_mul_responder (
   input  logic               clk,
   input  logic               resetn,
   input  logic signed [17:0] a,
   input  logic signed [17:0] b,
   input  logic               input_rdy,
   output logic signed [35:0] p,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

`ifdef SERIAL_MUL_RADIX4_EN
   // Index of the final iteration: 9 radix-4 digits cover 18 multiplier bits.
   localparam logic [4:0] LAST_ITER = 5'd8;
`else
   // Index of the final iteration: one multiplier bit per clock.
   localparam logic [4:0] LAST_ITER = 5'd17;
`endif

   // Unsigned magnitude of a signed 18-bit operand; -131072 maps to 131072.
   function automatic logic [17:0] magnitude(input logic [17:0] v);
      logic [17:0] res;
      if (v[17]) begin
         res = ~v + 18'd1;
      end else begin
         res = v;
      end
      return res;
   endfunction

   // Registered state
   state_t             state_r;
   logic signed [17:0] op_a_r;
   logic signed [17:0] op_b_r;
   logic [35:0]        mcand_r;    // |a|, shifted left as iterations retire
   logic [17:0]        mplier_r;   // |b|, shifted right as iterations retire
   logic               sign_r;
   logic [4:0]         counter_r;
   logic [35:0]        acc_r;
   logic               valid_r;
   logic signed [35:0] p_r;

   // Next-state values
   state_t             state_n;
   logic signed [17:0] op_a_n;
   logic signed [17:0] op_b_n;
   logic [35:0]        mcand_n;
   logic [17:0]        mplier_n;
   logic               sign_n;
   logic [4:0]         counter_n;
   logic [35:0]        acc_n;
   logic               valid_n;
   logic signed [35:0] p_n;

   // Decode helpers
   logic               mismatch_s;
   logic               running_s;
   logic               load_s;
   logic               abort_s;
   logic [35:0]        addend_s;

   // Handshake decode: operand mismatch, in-flight status, load/abort decisions.
   always_comb begin
      mismatch_s = (a != op_a_r) || (b != op_b_r);
      running_s  = (state_r != IDLE);
      busy       = input_rdy & (running_s | ~valid_r | mismatch_s);
      // From IDLE a product starts when nothing valid is held or operands moved;
      // once running (valid is already cleared) only an operand change restarts.
      if (state_r == IDLE) begin
         load_s = input_rdy & (~valid_r | mismatch_s);
      end else begin
         load_s = input_rdy & mismatch_s;
      end
      abort_s = ~input_rdy & running_s;
   end

`ifdef SERIAL_MUL_RADIX4_EN
   // Partial product for one radix-4 digit {b1,b0} of the multiplier.
   always_comb begin
      addend_s = 36'd0;
      if (mplier_r[0]) begin
         addend_s = mcand_r;
      end else begin
         addend_s = 36'd0;
      end
      if (mplier_r[1]) begin
         addend_s = addend_s + {mcand_r[34:0], 1'b0};
      end else begin
         addend_s = addend_s + 36'd0;
      end
   end
`else
   // Partial product for one multiplier bit.
   always_comb begin
      if (mplier_r[0]) begin
         addend_s = mcand_r;
      end else begin
         addend_s = 36'd0;
      end
   end
`endif

   // Next-state and datapath update: load, abort, iterate, fix up sign.
   always_comb begin
      state_n   = state_r;
      op_a_n    = op_a_r;
      op_b_n    = op_b_r;
      mcand_n   = mcand_r;
      mplier_n  = mplier_r;
      sign_n    = sign_r;
      counter_n = counter_r;
      acc_n     = acc_r;
      valid_n   = valid_r;
      p_n       = p_r;

      if (load_s) begin
         // Capture operands; any in-flight result is dropped, p is untouched.
         op_a_n    = a;
         op_b_n    = b;
         mcand_n   = {18'd0, magnitude(a)};
         mplier_n  = magnitude(b);
         sign_n    = a[17] ^ b[17];
         acc_n     = 36'd0;
         counter_n = 5'd0;
         valid_n   = 1'b0;
         state_n   = RUN;
      end else if (abort_s) begin
         // Initiator withdrew: abandon the computation, keep p.
         valid_n = 1'b0;
         state_n = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               state_n = IDLE;
            end
            RUN: begin
               acc_n     = acc_r + addend_s;
               counter_n = counter_r + 5'd1;
`ifdef SERIAL_MUL_RADIX4_EN
               mcand_n  = {mcand_r[33:0], 2'b00};
               mplier_n = {2'b00, mplier_r[17:2]};
`else
               mcand_n  = {mcand_r[34:0], 1'b0};
               mplier_n = {1'b0, mplier_r[17:1]};
`endif
               if (counter_r == LAST_ITER) begin
                  state_n = FIX;
               end else begin
                  state_n = RUN;
               end
            end
            FIX: begin
               // Magnitude product is at most 2^34, so the negation cannot overflow.
               if (sign_r) begin
                  p_n = 36'd0 - acc_r;
               end else begin
                  p_n = acc_r;
               end
               valid_n = 1'b1;
               state_n = IDLE;
            end
            default: begin
               valid_n = 1'b0;
               state_n = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r   <= IDLE;
         op_a_r    <= 18'sd0;
         op_b_r    <= 18'sd0;
         mcand_r   <= 36'd0;
         mplier_r  <= 18'd0;
         sign_r    <= 1'b0;
         counter_r <= 5'd0;
         acc_r     <= 36'd0;
         valid_r   <= 1'b0;
         p_r       <= 36'sd0;
      end else begin
         state_r   <= state_n;
         op_a_r    <= op_a_n;
         op_b_r    <= op_b_n;
         mcand_r   <= mcand_n;
         mplier_r  <= mplier_n;
         sign_r    <= sign_n;
         counter_r <= counter_n;
         acc_r     <= acc_n;
         valid_r   <= valid_n;
         p_r       <= p_n;
      end
   end

   // Registered product drives the output directly.
   always_comb begin
      p = p_r;
   end

endmodule

// File: tb/tb_serial_signed_18x18_mul_responder.sv
// Self-checking bench for serial_signed_18x18_mul_responder: directed scenarios and
// randomized operand/handshake traffic, checked every cycle against a transaction-level
// model (product = a*b, delivered a fixed number of edges after operand capture).
module tb_serial_signed_18x18_mul_responder;

`ifdef SERIAL_MUL_RADIX4_EN
   localparam int LAT = 10;
`else
   localparam int LAT = 19;
`endif

   logic               clk = 1'b0;
   logic               resetn;
   logic signed [17:0] a;
   logic signed [17:0] b;
   logic               input_rdy;
   logic signed [35:0] p;
   logic               busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   longint m_p;
   longint m_op_a;
   longint m_op_b;
   int     m_left;      // edges until the product lands; 0 = nothing in flight
   bit     m_valid;
   bit     last_busy;

   always #5 clk = ~clk;

   serial_signed_18x18_mul_responder dut (
      .clk       (clk),
      .resetn    (resetn),
      .a         (a),
      .b         (b),
      .input_rdy (input_rdy),
      .p         (p),
      .busy      (busy)
   );

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_p     = 0;
      m_op_a  = 0;
      m_op_b  = 0;
      m_left  = 0;
      m_valid = 1'b0;
   endtask

   // One clock edge of the handshake rules, at transaction level.
   task automatic model_edge(input bit r, input longint va, input longint vb);
      bit mism;
      mism = (va != m_op_a) || (vb != m_op_b);
      if (!r) begin
         if (m_left != 0) begin
            m_left  = 0;
            m_valid = 1'b0;
         end
      end else if ((m_left == 0) ? (!m_valid || mism) : mism) begin
         m_op_a  = va;
         m_op_b  = vb;
         m_valid = 1'b0;
         m_left  = LAT;
      end else if (m_left != 0) begin
         m_left--;
         if (m_left == 0) begin
            m_p     = m_op_a * m_op_b;
            m_valid = 1'b1;
         end
      end
   endtask

   // Apply inputs just after an edge, check outputs mid-cycle, then advance one edge.
   task automatic cycle(input bit r, input logic signed [17:0] va, input logic signed [17:0] vb);
      longint exp_busy;
      input_rdy = r;
      a         = va;
      b         = vb;
      @(negedge clk);
      exp_busy = (r && (m_left != 0 || !m_valid || longint'(va) != m_op_a || longint'(vb) != m_op_b)) ? 1 : 0;
      check_val("busy", longint'(busy), exp_busy);
      check_val("p", p, m_p);
      last_busy = busy;
      @(posedge clk);
      model_edge(r, va, vb);
      #1;
   endtask

   task automatic run(input int n, input bit r, input logic signed [17:0] va, input logic signed [17:0] vb);
      for (int i = 0; i < n; i++) begin
         cycle(r, va, vb);
      end
   endtask

   function automatic logic signed [17:0] pick();
      logic [31:0] rnd;
      logic [17:0] v;
      rnd = $urandom;
      case ($urandom_range(0, 7))
         0:       v = 18'h20000;
         1:       v = 18'h1FFFF;
         2:       v = 18'h00000;
         3:       v = 18'h3FFFF;
         4:       v = 18'h00001;
         default: v = rnd[17:0];
      endcase
      return v;
   endfunction

   initial begin
      int                 busy_cnt;
      logic signed [17:0] ra;
      logic signed [17:0] rb;
      bit                 rr;

      resetn    = 1'b0;
      input_rdy = 1'b0;
      a         = 18'sd0;
      b         = 18'sd0;
      model_reset();
      last_busy = 1'b0;
      @(posedge clk);
      #1;
      check_val("reset_p", p, 0);
      check_val("reset_busy", longint'(busy), 0);
      resetn = 1'b1;
      run(2, 1'b0, 18'sd0, 18'sd0);

      // 1: basic product and busy window, then held operands stay quiet
      busy_cnt = 0;
      for (int i = 0; i < LAT + 12; i++) begin
         cycle(1'b1, 18'sd3, 18'sd5);
         busy_cnt += int'(last_busy);
      end
      check_val("busy_window", busy_cnt, LAT + 1);
      check_val("p_3x5", p, 15);

      // 2: corner operands
      run(LAT + 2, 1'b1, -18'sd131071 - 18'sd1, -18'sd131071 - 18'sd1);
      check_val("p_min_x_min", p, 64'sd17179869184);
      run(LAT + 2, 1'b1, -18'sd131071 - 18'sd1, 18'sd131071);
      check_val("p_min_x_max", p, -64'sd17179738112);
      run(LAT + 2, 1'b1, 18'sd0, -18'sd1);
      check_val("p_0_x_m1", p, 0);

      // 3: SVF-style back-to-back, only b changes
      run(LAT + 2, 1'b1, 18'sd1000, 18'sd65536);
      check_val("p_svf1", p, 64'sd65536000);
      run(LAT + 2, 1'b1, 18'sd1000, -18'sd200);
      check_val("p_svf2", p, -64'sd200000);

      // 4: operand change mid-RUN discards the stale product
      run(7, 1'b1, 18'sd7, 18'sd9);
      run(LAT + 1, 1'b1, -18'sd4, 18'sd9);
      check_val("p_restart", p, -36);

      // 5: input_rdy withdrawn mid-RUN, then full recompute
      run(5, 1'b1, 18'sd12, 18'sd12);
      run(3, 1'b0, 18'sd12, 18'sd12);
      check_val("p_hold_on_abort", p, -36);
      run(LAT + 2, 1'b1, 18'sd12, 18'sd12);
      check_val("p_12x12", p, 144);

      // 6: asynchronous reset during RUN
      run(6, 1'b1, 18'sd100, 18'sd100);
      resetn = 1'b0;
      #1;
      model_reset();
      check_val("async_rst_p", p, 0);
      check_val("async_rst_busy", longint'(busy), 1);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      run(LAT + 2, 1'b1, 18'sd100, 18'sd100);
      check_val("p_100x100", p, 10000);

      // Randomized traffic: sporadic operand changes and input_rdy drops
      ra = pick();
      rb = pick();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) ra = pick();
         if ($urandom_range(0, 39) == 0) rb = pick();
         rr = ($urandom_range(0, 29) != 0);
         cycle(rr, ra, rb);
      end
      // Let the last product settle with a final known operand pair
      run(LAT + 2, 1'b1, -18'sd1234, 18'sd567);
      check_val("p_final", p, -699678);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
